move_seq_player: RTL and testbench
==================================

// Module: move_seq_player
// PURPOSE
// - Initiator for the 24-bit single-port move memory (combinational read, 1-cycle write): records a stream of
//   24-bit move words at addresses 0..count-1, then replays them in order over a valid/ready stream.
// - Sits between the solver core (producer/consumer of moves) and the move memory; sole driver of mem_*.
// PARAMETERS
// - DW     24   data word width; matches memory word
// - DEPTH  256  max words recorded; memory depth
// - AW     8    internal pointer width, log2(DEPTH); mem_addr is zero-extended to 24 bits
// PORTS
// - clk         in   1     clock, rising edge
// - rst_n       in   1     reset, asynchronous assert, active-low
// - rec_valid   in   1     record word offered
// - rec_ready   out  1     record word accepted when rec_valid&rec_ready
// - rec_data    in   DW    word to record
// - clear       in   1     empty the sequence (count<=0); IDLE only
// - play_start  in   1     begin replay; IDLE only
// - play_valid  out  1     replay word available
// - play_ready  in   1     consumer takes word when play_valid&play_ready
// - play_data   out  DW    replay word
// - done        out  1     1-cycle pulse after last replay handshake
// - busy        out  1     state != IDLE
// - full        out  1     count == DEPTH
// - count       out  AW+1  words currently recorded
// - mem_addr    out  24    memory address, registered
// - mem_wdata   out  DW    memory write data, registered
// - mem_we      out  1     memory write enable, registered, 1-cycle pulses only
// - mem_rdata   in   DW    memory read data, valid combinationally for current mem_addr
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; count=0, ptr=0; mem_addr=0, mem_wdata=0, mem_we=0;
//   play_valid=0, play_data=0, done=0. Reset mid-record or mid-replay aborts immediately, no completion.
// - States: IDLE, FETCH, PRESENT, DONE.
// - rec_ready = (state==IDLE) & ~full & ~play_start & ~clear (combinational).
// - Record: on rec handshake at edge N, during cycle N+1 drive mem_we=1, mem_addr=count(old), mem_wdata=rec_data;
//   count increments at edge N. Back-to-back handshakes allowed: 1 word/cycle. mem_we=0 otherwise.
// - full: rec_ready low and further rec_valid stalls; count never exceeds DEPTH; no wrap of count.
// - clear in IDLE: count<=0 next edge; wins over rec_valid same cycle. Ignored outside IDLE.
// - play_start in IDLE, count>0: ptr<=first index, mem_addr<=ptr value, -> FETCH. count==0: ignored, stays IDLE,
//   no done pulse. play_start beats rec_valid in the same cycle (rec_ready forced low).
// - FETCH (1 cycle): mem_we=0; capture mem_rdata into play_data; play_valid<=1; -> PRESENT.
// - PRESENT: hold play_data/play_valid stable until play_ready. On handshake: last word -> DONE, play_valid<=0;
//   else advance ptr, mem_addr<=new ptr, play_valid<=0, -> FETCH. Throughput 1 word / 2 cycles.
// - DONE: done=1 for exactly this cycle; -> IDLE. Replay is non-destructive: count unchanged, can replay again.
// - Forward order: ptr 0,1,...,count-1. rec_valid, clear, play_start ignored while busy.
// - mem_addr[23:AW]=0 always; write in flight at the play_start edge completes before first FETCH read.
// CONFIGURATION
// - REVERSE_PLAY_EN defined: extra input play_rev (1 bit), sampled with play_start; play_rev=1 replays
//   count-1 down to 0 (undo sequence), play_rev=0 forward. Last word is index 0 in reverse mode.
// - REVERSE_PLAY_EN undefined: no play_rev port; forward only.
// TESTING
// - Reset: rst_n=0 mid-PRESENT -> same cycle play_valid=0, mem_we=0, count=0, busy=0; rec_ready=1 after release.
// - Record 3 words 0x000011,0x000022,0x000033 back-to-back -> mem_we pulses addr 0,1,2, count=3.
// - Replay with play_ready=1 -> play_data 0x000011,0x000022,0x000033 on alternate cycles, then done pulse 1 cycle.
// - Fill 256 words -> full=1, rec_ready=0; 257th rec_valid held stalls, count stays 256, no mem_we.
// - play_start with count=0 -> stays IDLE, no play_valid, no done; clear+rec_valid same cycle -> count=0, no write.
// - REVERSE_PLAY_EN, play_rev=1 after 3-word record; play_ready toggled -> 0x000033,0x000022,0x000011, data stable.

Source files
------------

// File: rtl/move_seq_player.sv
// Records 24-bit move words into a single-port memory and replays them over valid/ready.
// Optional `REVERSE_PLAY_EN adds play_rev for count-1..0 (undo) replay order.
module move_seq_player #(
  parameter int DW    = 24,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rec_valid,
  output logic          rec_ready,
  input  logic [DW-1:0] rec_data,
  input  logic          clear,
  input  logic          play_start,
`ifdef REVERSE_PLAY_EN
  input  logic          play_rev,
`endif
  output logic          play_valid,
  input  logic          play_ready,
  output logic [DW-1:0] play_data,
  output logic          done,
  output logic          busy,
  output logic          full,
  output logic [AW:0]   count,
  output logic [23:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          pv_q, pv_d;
  logic [DW-1:0] pd_q, pd_d;
  logic          rev_q, rev_d;
  logic          start_rev;

  logic          idle;
  logic          is_full;
  logic          rec_fire;
  logic          start_ok;
  logic          clr_ok;
  logic          last;
  logic [AW:0]   cnt_m1;
  logic [AW-1:0] first_idx;
  logic [AW-1:0] ptr_nxt;

`ifdef REVERSE_PLAY_EN
  assign start_rev = play_rev;
`else
  assign start_rev = 1'b0;
`endif

  assign idle      = (state_q == IDLE);
  assign is_full   = (count_q == DEPTH_C);
  assign rec_ready = idle & ~is_full
                   & ~play_start & ~clear;
  assign rec_fire  = rec_valid & rec_ready;
  assign start_ok  = idle & play_start
                   & (count_q != '0);
  assign clr_ok    = idle & clear & ~start_ok;

  assign cnt_m1    = count_q - 1'b1;
  assign first_idx = start_rev ? cnt_m1[AW-1:0]
                               : '0;
  assign last      = rev_q ? (ptr_q == '0)
                           : (ptr_q == cnt_m1[AW-1:0]);
  assign ptr_nxt   = rev_q ? ptr_q - 1'b1
                           : ptr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: state_d = PRESENT;
      PRESENT: begin
        if (play_ready) begin
          state_d = last ? DONE : FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    count_d = count_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    pv_d    = pv_q;
    pd_d    = pd_q;
    rev_d   = rev_q;
    unique case (1'b1)
      rec_fire: begin
        we_d    = 1'b1;
        addr_d  = count_q[AW-1:0];
        wdata_d = rec_data;
        count_d = count_q + 1'b1;
      end
      clr_ok: begin
        count_d = '0;
      end
      start_ok: begin
        ptr_d  = first_idx;
        addr_d = first_idx;
        rev_d  = start_rev;
      end
      (state_q == FETCH): begin
        pd_d = mem_rdata;
        pv_d = 1'b1;
      end
      (state_q == PRESENT && play_ready): begin
        pv_d = 1'b0;
        if (!last) begin
          ptr_d  = ptr_nxt;
          addr_d = ptr_nxt;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      rev_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      rev_q   <= rev_d;
    end
  end

  assign full       = is_full;
  assign count      = count_q;
  assign mem_addr   = {{(24-AW){1'b0}}, addr_q};
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign play_valid = pv_q;
  assign play_data  = pd_q;

endmodule

// File: tb/tb_move_seq_player.sv
// Scoreboard bench for move_seq_player: queued expected writes/replay words,
// monitor compares on mem_we and play handshakes.
module tb_move_seq_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  logic [23:0] rec_data = '0;
  logic        clear = 1'b0;
  logic        play_start = 1'b0;
  logic        play_rev = 1'b0;
  logic        play_valid;
  logic        play_ready = 1'b1;
  logic [23:0] play_data;
  logic        done;
  logic        busy;
  logic        full;
  logic [8:0]  count;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic [23:0] mem_rdata;

  logic [23:0] mem [256];

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  int exp_done = 0;
  int done_seen = 0;
  int rdy_mode = 0;
  int cyc = 0;

  logic [23:0] exp_play[$];
  logic [31:0] exp_wr[$];
  logic [23:0] recw[$];

  always #5 clk = ~clk;

  move_seq_player dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .clear     (clear),
    .play_start(play_start),
`ifdef REVERSE_PLAY_EN
    .play_rev  (play_rev),
`endif
    .play_valid(play_valid),
    .play_ready(play_ready),
    .play_data (play_data),
    .done      (done),
    .busy      (busy),
    .full      (full),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // ready pattern: 0 always, 1 never, 2 one cycle in three
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        0: play_ready = 1'b1;
        1: play_ready = 1'b0;
        default: play_ready = (cyc % 3 == 0);
      endcase
    end
  end

  initial begin
    logic        prev_stall;
    logic        prev_done;
    logic [23:0] prev_data;
    logic [31:0] w;
    logic [23:0] e;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (mem_we) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), {24'h0, w[31:24]});
            chk("wr_data", 32'(mem_wdata), {8'h0, w[23:0]});
          end
        end
        if (prev_stall && play_valid) begin
          chk("data_stable", 32'(play_data), 32'(prev_data));
        end
        if (play_valid && play_ready) begin
          if (exp_play.size() == 0) begin
            chk("unexpected_play", 32'(play_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_play.pop_front();
            chk("play_data", 32'(play_data), 32'(e));
          end
        end
        if (done) begin
          done_seen++;
          if (prev_done) chk("done_width", 32'd2, 32'd1);
        end
        prev_done  = done;
        prev_stall = play_valid && !play_ready;
        prev_data  = play_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_word(input logic [23:0] d);
    int n;
    rec_valid = 1'b1;
    rec_data  = d;
    n = 0;
    @(negedge clk);
    while (!rec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rec_ready) begin
      exp_wr.push_back({8'(exp_cnt), d});
      recw.push_back(d);
      exp_cnt++;
    end else begin
      chk("rec_timeout", 32'd0, 32'd1);
    end
    step();
  endtask

  task automatic play_seq(input logic rev, output int ncyc);
    int n;
    if (rev) begin
      for (int i = recw.size() - 1; i >= 0; i--) exp_play.push_back(recw[i]);
    end else begin
      foreach (recw[i]) exp_play.push_back(recw[i]);
    end
    exp_done++;
    play_rev   = rev;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    if (!done) chk("play_timeout", 32'd0, 32'd1);
    ncyc = n;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_pvalid", 32'(play_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rec_ready_idle", 32'(rec_ready), 32'd1);
    step();

    rec_word(24'h000011);
    rec_word(24'h000022);
    rec_word(24'h000033);
    rec_valid = 1'b0;
    @(negedge clk);
    chk("count_3", 32'(count), 32'd3);
    step();

    rdy_mode = 0;
    play_seq(1'b0, nc);
    chk("fwd_cycles", 32'(nc), 32'd7);
    @(negedge clk);
    chk("count_kept", 32'(count), 32'd3);
    chk("idle_after", 32'(busy), 32'd0);
    step();

    rdy_mode = 2;
    step();
    play_seq(1'b0, nc);
`ifdef REVERSE_PLAY_EN
    play_seq(1'b1, nc);
`endif
    rdy_mode = 0;
    step();

    clear     = 1'b1;
    rec_valid = 1'b1;
    rec_data  = 24'hABCDEF;
    @(negedge clk);
    chk("clr_rec_ready", 32'(rec_ready), 32'd0);
    step();
    clear     = 1'b0;
    rec_valid = 1'b0;
    recw.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("clr_count", 32'(count), 32'd0);
    step();

    play_start = 1'b1;
    step();
    play_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_busy", 32'(busy), 32'd0);
      chk("empty_pvalid", 32'(play_valid), 32'd0);
    end
    step();

    for (int i = 0; i < 256; i++) rec_word(24'h000100 + 24'(i));
    rec_data = 24'hFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_rdy", 32'(rec_ready), 32'd0);
      chk("full_count", 32'(count), 32'd256);
    end
    step();
    rec_valid = 1'b0;
    play_seq(1'b0, nc);
    chk("full_cycles", 32'(nc), 32'd513);

    rdy_mode = 1;
    step();
    step();
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!play_valid && n < 20);
    chk("pre_rst_pvalid", 32'(play_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pvalid", 32'(play_valid), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    recw.delete();
    exp_cnt = 0;
    step();
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(rec_ready), 32'd1);
    chk("post_rst_done", 32'(done), 32'd0);

    repeat (3) @(negedge clk);
    chk("play_q_empty", 32'(exp_play.size()), 32'd0);
    chk("wr_q_empty", 32'(exp_wr.size()), 32'd0);
    chk("done_pulses", 32'(done_seen), 32'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
